axil_pkt_writer: RTL and testbench
==================================

# axil_pkt_writer

AXI4-Lite write-channel master that feeds the packet validator/sorter slave. It accepts 32-bit packet words on a simple valid/ready request port and issues each one as a single AXI4-Lite write: address 0x00 for data words, 0x04 for the commit word. It waits for the slave's write response, reports the BRESP code upstream and keeps running totals of valid, invalid and error outcomes. It sits between the packet source (test generator or upstream logic) and the sorter slave's AW/W/B channels.

## Interface
- ADDR_W, 32, AXI address width
- DATA_W, 32, AXI data width; also the request word width
- TIMEOUT_CYC, 64, B-channel wait limit in cycles; used only when AXIL_WR_TIMEOUT_EN is defined
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  asynchronous, active-low reset
- req_valid  in  1  request word present
- req_ready  out  1  writer idle and able to take a request
- req_data  in  DATA_W  packet word
- req_commit  in  1  1 = commit write to 0x04, 0 = data write to 0x00
- AWVALID / AWREADY  out / in  1 / 1  write-address handshake
- AWADDR  out  ADDR_W  0x00 or 0x04
- AWPROT  out  3  constant 3'b000
- WVALID / WREADY  out / in  1 / 1  write-data handshake
- WDATA  out  DATA_W  registered copy of req_data
- WSTRB  out  DATA_W/8  constant all-ones
- BVALID / BREADY  in / out  1 / 1  write-response handshake
- BRESP  in  2  slave response
- resp_valid  out  1  one-cycle pulse: a write has completed
- resp_code  out  2  BRESP captured for that write
- resp_timeout  out  1  qualifies resp_valid: write ended by timeout
- valid_cnt, invalid_cnt, err_cnt  out  8 each  saturating outcome counters

## Operation
- States: IDLE, ADDR_DATA, RESP, DONE.
- IDLE: req_ready=1. On req_valid&req_ready: latch req_data into WDATA, set AWADDR = req_commit ? 0x04 : 0x00, go to ADDR_DATA.
- ADDR_DATA: AWVALID and WVALID are both asserted on entry. Each channel drops its VALID independently, the cycle after its own handshake. Two internal flags record aw_done and w_done. Once both are set, go to RESP. The AW and W handshakes may land in the same cycle or in either order.
- RESP: BREADY=1. On BVALID&BREADY: capture BRESP into resp_code, go to DONE.
- DONE: resp_valid=1 for one cycle, update counters, return to IDLE.
- Counter update on commit writes (AWADDR 0x04):
  - BRESP 2'b00 increments valid_cnt.
  - BRESP 2'b01 increments invalid_cnt.
- Counter update on any write: BRESP 2'b10 or 2'b11 increments err_cnt.
- Data writes (AWADDR 0x00) with OKAY/EXOKAY change no counter.
- All counters saturate at 8'hFF and never wrap.
- Once asserted, AWVALID and WVALID are never deasserted before their handshake. AWADDR and WDATA are stable while their VALID is high.
- Requests are not accepted outside IDLE. At most one write is outstanding.

## Timing
- Reset values:
  - all VALID and READY outputs 0; req_ready 0 while rst is low.
  - AWADDR, WDATA, resp_code, all counters 0; resp_valid 0; resp_timeout 0.
  - State IDLE. req_ready rises in the first clock after reset is released.
- Request accepted at edge N: AWVALID/WVALID are high from N+1.
- Slave that is always ready: handshakes at N+1, BREADY high from N+2. With BVALID already high, B handshake at N+2, resp_valid at N+3, req_ready high again at N+4.
- Minimum throughput: one write per 4 cycles.
- Reset asserted mid-transaction: all outputs return to their reset values immediately (asynchronous). The in-flight write is abandoned and no resp_valid is produced.
- BVALID arriving before both AW and W complete is ignored: BREADY stays 0 until RESP.

## Configuration
- AXIL_WR_TIMEOUT_EN defined: a cycle counter runs in RESP.
  - If TIMEOUT_CYC cycles pass without BVALID, drop BREADY and go to DONE.
  - DONE then drives resp_code=2'b10, resp_timeout=1, and increments err_cnt.
- AXIL_WR_TIMEOUT_EN undefined: RESP waits indefinitely. resp_timeout is tied to 0 and no counter logic exists.

## Structure
- Package axil_pkg:
  - BRESP constants RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11
  - addresses ADDR_DATA=32'h00, ADDR_COMMIT=32'h04
  - state enum wr_state_t
- One sub-module: axil_sat_ctr, an 8-bit saturating counter with an inc input. It is instantiated three times.

## Test plan
- Ready slave, data write 0x12345678: AW/W at N+1 with AWADDR=0x00, BRESP=00 -> resp_valid at N+3, resp_code=00, all counters 0.
- Commit write 0xA5000000, BRESP=00 -> AWADDR=0x04, valid_cnt=1. Commit write 0x3C000000, BRESP=01 -> invalid_cnt=1.
- AWREADY delayed 3 cycles, WREADY immediate -> WVALID drops after 1 cycle, AWVALID held 4 cycles with AWADDR stable, BREADY only after both handshakes.
- 260 commit writes with BRESP=10 -> err_cnt saturates at 8'hFF.
- Reset pulled low during RESP -> BREADY=0 and req_ready=0 immediately. After release, req_ready=1 and no resp_valid is seen.
- AXIL_WR_TIMEOUT_EN, TIMEOUT_CYC=8, BVALID never asserted -> resp_valid with resp_timeout=1 and resp_code=10 eight cycles after entering RESP, err_cnt=1.

Source files
------------

// File: rtl/axil_pkt_writer_pkg.sv
// Shared constants and state type for the AXI4-Lite packet writer.
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [31:0] ADDR_DATA   = 32'h0000_0000;
  localparam logic [31:0] ADDR_COMMIT = 32'h0000_0004;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR_DATA,
    S_RESP,
    S_DONE
  } wr_state_t;

endpackage

// File: rtl/axil_pkt_writer_if.sv
// AXI4-Lite write-channel bundle (AW, W, B) between the packet writer and the sorter slave.
interface axil_pkt_writer_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic                  AWVALID;
  logic                  AWREADY;
  logic [ADDR_W-1:0]     AWADDR;
  logic [2:0]            AWPROT;
  logic                  WVALID;
  logic                  WREADY;
  logic [DATA_W-1:0]     WDATA;
  logic [DATA_W/8-1:0]   WSTRB;
  logic                  BVALID;
  logic                  BREADY;
  logic [1:0]            BRESP;

  modport master (
    output AWVALID, AWADDR, AWPROT, WVALID, WDATA, WSTRB, BREADY,
    input  AWREADY, WREADY, BVALID, BRESP
  );

  modport slave (
    input  AWVALID, AWADDR, AWPROT, WVALID, WDATA, WSTRB, BREADY,
    output AWREADY, WREADY, BVALID, BRESP
  );

endinterface

// File: rtl/axil_pkt_writer_sat_ctr.sv
// 8-bit outcome counter that sticks at 8'hFF instead of wrapping.
module axil_sat_ctr (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  output logic [7:0] count
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= 8'd0;
    end else if (inc && (count != 8'hFF)) begin
      count <= count + 8'd1;
    end
  end

endmodule

// File: rtl/axil_pkt_writer.sv
// AXI4-Lite write master: one single-beat write per packet word, BRESP reported upstream
// with saturating outcome totals. Optional B-channel timeout under AXIL_WR_TIMEOUT_EN.
module axil_pkt_writer
  import axil_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [DATA_W-1:0]   req_data,
  input  logic                req_commit,
  axil_pkt_writer_if.master   axi,
  output logic                resp_valid,
  output logic [1:0]          resp_code,
  output logic                resp_timeout,
  output logic [7:0]          valid_cnt,
  output logic [7:0]          invalid_cnt,
  output logic [7:0]          err_cnt,
  output wr_state_t           state_dbg
);

  // Handshakes: a transfer happens on a rising edge where VALID and READY are both high;
  // once raised, VALID and its payload hold steady until that edge.

  typedef logic [$clog2(TIMEOUT_CYC + 1)-1:0] to_cnt_t;

  wr_state_t         state, state_nxt;
  logic              run_q;
  logic              awvalid_q, wvalid_q;
  logic              aw_done_q, w_done_q;
  logic              commit_q;
  logic [ADDR_W-1:0] awaddr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [1:0]        resp_code_q;
  logic              accept, aw_hs, w_hs, b_hs, to_fire, done;

  assign req_ready = run_q && (state == S_IDLE);
  assign accept    = req_valid && req_ready;
  assign aw_hs     = awvalid_q && axi.AWREADY;
  assign w_hs      = wvalid_q && axi.WREADY;
  assign b_hs      = (state == S_RESP) && axi.BVALID;
  assign done      = (state == S_DONE);

`ifdef AXIL_WR_TIMEOUT_EN
  to_cnt_t to_cnt;
  logic    timeout_q;

  assign to_fire = (state == S_RESP) && !axi.BVALID && (to_cnt == to_cnt_t'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_cnt    <= '0;
      timeout_q <= 1'b0;
    end else begin
      to_cnt <= (state == S_RESP) ? to_cnt + 1'b1 : '0;
      if (accept) begin
        timeout_q <= 1'b0;
      end else if (to_fire) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign resp_timeout = done && timeout_q;
`else
  assign to_fire      = 1'b0;
  assign resp_timeout = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (accept) state_nxt = S_ADDR_DATA;
      S_ADDR_DATA: if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_nxt = S_RESP;
      S_RESP:      if (b_hs || to_fire) state_nxt = S_DONE;
      S_DONE:      state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      run_q       <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      commit_q    <= 1'b0;
      awaddr_q    <= '0;
      wdata_q     <= '0;
      resp_code_q <= 2'b00;
    end else begin
      state <= state_nxt;
      run_q <= 1'b1;
      if (accept) begin
        awaddr_q  <= req_commit ? ADDR_W'(ADDR_COMMIT) : ADDR_W'(ADDR_DATA);
        wdata_q   <= req_data;
        commit_q  <= req_commit;
        awvalid_q <= 1'b1;
        wvalid_q  <= 1'b1;
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
      end else begin
        // Each channel retires on its own edge; the other may still be waiting.
        if (aw_hs) begin
          awvalid_q <= 1'b0;
          aw_done_q <= 1'b1;
        end
        if (w_hs) begin
          wvalid_q <= 1'b0;
          w_done_q <= 1'b1;
        end
      end
      if (b_hs) begin
        resp_code_q <= axi.BRESP;
      end else if (to_fire) begin
        resp_code_q <= RESP_SLVERR;
      end
    end
  end

  assign axi.AWVALID = awvalid_q;
  assign axi.AWADDR  = awaddr_q;
  assign axi.AWPROT  = 3'b000;
  assign axi.WVALID  = wvalid_q;
  assign axi.WDATA   = wdata_q;
  assign axi.WSTRB   = '1;
  assign axi.BREADY  = (state == S_RESP);

  assign resp_valid = done;
  assign resp_code  = resp_code_q;
  assign state_dbg  = state;

  axil_sat_ctr u_valid_ctr (
    .clk   (clk),
    .rst   (rst),
    .inc   (done && commit_q && (resp_code_q == RESP_OKAY)),
    .count (valid_cnt)
  );

  axil_sat_ctr u_invalid_ctr (
    .clk   (clk),
    .rst   (rst),
    .inc   (done && commit_q && (resp_code_q == RESP_EXOKAY)),
    .count (invalid_cnt)
  );

  axil_sat_ctr u_err_ctr (
    .clk   (clk),
    .rst   (rst),
    .inc   (done && resp_code_q[1]),
    .count (err_cnt)
  );

endmodule

// File: tb/tb_axil_pkt_writer.sv
// Bench for axil_pkt_writer: scripted/random AXI-Lite slave plus an outcome model.
module tb_axil_pkt_writer;
  import axil_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
`ifdef AXIL_WR_TIMEOUT_EN
  localparam int TO_CYC = 8;
`else
  localparam int TO_CYC = 64;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          req_valid = 1'b0;
  logic          req_commit = 1'b0;
  logic [DW-1:0] req_data = '0;
  logic          req_ready, resp_valid, resp_timeout;
  logic [1:0]    resp_code;
  logic [7:0]    valid_cnt, invalid_cnt, err_cnt;
  wr_state_t     state_dbg;

  axil_pkt_writer_if #(.ADDR_W(AW), .DATA_W(DW)) axi ();

  axil_pkt_writer #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO_CYC)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_commit(req_commit), .axi(axi),
    .resp_valid(resp_valid), .resp_code(resp_code), .resp_timeout(resp_timeout),
    .valid_cnt(valid_cnt), .invalid_cnt(invalid_cnt), .err_cnt(err_cnt),
    .state_dbg(state_dbg)
  );

  int tests = 0;
  int fails = 0;

  // ---------------- slave configuration and monitor state ----------------
  int aw_dly = 0, w_dly = 0, b_dly = 0;
  bit b_early = 0;
  logic [1:0] b_resp = 2'b00;

  bit aw_got = 0, w_got = 0;
  int b_hs_total = 0;
  int aw_hi_total = 0, w_hi_total = 0;
  int proto_err = 0;
  bit aw_pend = 0, w_pend = 0, prev_rv = 0;
  logic [AW-1:0] aw_pend_addr;
  logic [DW-1:0] w_pend_data;
  logic [AW-1:0] got_aw_q[$];
  logic [DW-1:0] got_w_q[$];
  logic [2:0]    got_resp_q[$];

  // Posedge monitor: records handshakes and checks hold / ordering rules.
  initial begin
    forever begin
      @(posedge clk);
      if (!rst) begin
        aw_got = 0; w_got = 0; aw_pend = 0; w_pend = 0; prev_rv = 0;
      end else begin
        if (axi.BREADY && !(aw_got && w_got)) proto_err++;
        if (aw_pend && (!axi.AWVALID || axi.AWADDR !== aw_pend_addr)) proto_err++;
        if (w_pend && (!axi.WVALID || axi.WDATA !== w_pend_data)) proto_err++;
        aw_pend = axi.AWVALID && !axi.AWREADY; aw_pend_addr = axi.AWADDR;
        w_pend  = axi.WVALID && !axi.WREADY;   w_pend_data  = axi.WDATA;
        if (axi.AWVALID) aw_hi_total++;
        if (axi.WVALID) w_hi_total++;
        if (axi.AWVALID && axi.AWREADY) begin got_aw_q.push_back(axi.AWADDR); aw_got = 1; end
        if (axi.WVALID && axi.WREADY) begin got_w_q.push_back(axi.WDATA); w_got = 1; end
        if (axi.BVALID && axi.BREADY) begin b_hs_total++; aw_got = 0; w_got = 0; end
        if (resp_valid) begin
          got_resp_q.push_back({resp_timeout, resp_code});
          aw_got = 0; w_got = 0;
          if (prev_rv) proto_err++;
        end
        prev_rv = resp_valid;
      end
    end
  end

  // Negedge slave driver.
  initial begin
    int aw_cnt, w_cnt, b_cnt, b_seen;
    aw_cnt = 0; w_cnt = 0; b_cnt = 0; b_seen = 0;
    axi.AWREADY = 0; axi.WREADY = 0; axi.BVALID = 0; axi.BRESP = 2'b00;
    forever begin
      @(negedge clk);
      axi.BRESP = b_resp;
      if (!rst) begin
        axi.AWREADY = 0; axi.WREADY = 0; axi.BVALID = 0;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; b_seen = b_hs_total;
      end else begin
        if (axi.AWVALID && !aw_got) begin
          if (aw_cnt >= aw_dly) axi.AWREADY = 1; else begin axi.AWREADY = 0; aw_cnt++; end
        end else begin axi.AWREADY = 0; aw_cnt = 0; end
        if (axi.WVALID && !w_got) begin
          if (w_cnt >= w_dly) axi.WREADY = 1; else begin axi.WREADY = 0; w_cnt++; end
        end else begin axi.WREADY = 0; w_cnt = 0; end
        if (b_seen != b_hs_total) begin
          b_seen = b_hs_total; axi.BVALID = 0; b_cnt = 0;
        end else if (!axi.BVALID) begin
          if (b_early && (axi.AWVALID || axi.WVALID)) axi.BVALID = 1;
          else if (aw_got && w_got) begin
            if (b_cnt >= b_dly) axi.BVALID = 1; else b_cnt++;
          end else b_cnt = 0;
        end
      end
    end
  end

  // ---------------- reference model / scoreboard ----------------
  int ev = 0, ei = 0, ee = 0;
  logic [2:0]    exp_q[$];
  logic [AW-1:0] exp_addr_q[$];
  logic [DW-1:0] exp_data_q[$];

  function automatic void model_write(logic [DW-1:0] d, logic c, logic [1:0] br, logic to);
    logic [1:0] code;
    code = to ? 2'b10 : br;
    exp_q.push_back({to, code});
    exp_addr_q.push_back(c ? 32'd4 : 32'd0);
    exp_data_q.push_back(d);
    if (code >= 2'd2) begin
      if (ee < 255) ee++;
    end else if (c && code == 2'd0) begin
      if (ev < 255) ev++;
    end else if (c && code == 2'd1) begin
      if (ei < 255) ei++;
    end
  endfunction

  // ---------------- drivers ----------------
  task automatic issue_req(input logic [DW-1:0] d, input logic c, output bit ok);
    @(negedge clk);
    req_valid = 1; req_data = d; req_commit = c;
    for (int i = 0; i < 200 && !req_ready; i++) @(negedge clk);
    ok = req_ready;
    if (!ok) begin
      tests++; fails++;
      $display("FAIL req_accept_timeout: req_ready=%b required 1 within 200 cycles", req_ready);
      req_valid = 0;
      return;
    end
    @(posedge clk);
    #1;
    req_valid = 0;
  endtask

  task automatic do_write(input logic [DW-1:0] d, input logic c, output logic [2:0] rsp,
                          output logic [AW-1:0] a, output logic [DW-1:0] wd);
    bit ok;
    rsp = 'x; a = 'x; wd = 'x;
    issue_req(d, c, ok);
    if (!ok) return;
    for (int i = 0; i < 400 && got_resp_q.size() == 0; i++) @(negedge clk);
    if (got_resp_q.size() == 0) begin
      tests++; fails++;
      $display("FAIL resp_wait_timeout: resp_valid not seen, required within 400 cycles");
      return;
    end
    rsp = got_resp_q.pop_front();
    if (got_aw_q.size() > 0) a = got_aw_q.pop_front();
    if (got_w_q.size() > 0) wd = got_w_q.pop_front();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(negedge clk);
    tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL rst_req_ready: got %b required 0", req_ready); end
    tests++; if ({axi.AWVALID, axi.WVALID, axi.BREADY, resp_valid, resp_timeout} !== 5'b0) begin fails++; $display("FAIL rst_valids: got %b required 00000", {axi.AWVALID, axi.WVALID, axi.BREADY, resp_valid, resp_timeout}); end
    tests++; if ({axi.AWADDR, axi.WDATA} !== 64'd0) begin fails++; $display("FAIL rst_addr_data: got %h required 0", {axi.AWADDR, axi.WDATA}); end
    tests++; if ({resp_code, valid_cnt, invalid_cnt, err_cnt} !== 26'd0) begin fails++; $display("FAIL rst_counters: got %h required 0", {resp_code, valid_cnt, invalid_cnt, err_cnt}); end
    tests++; if ({axi.AWPROT, axi.WSTRB} !== 7'b000_1111) begin fails++; $display("FAIL rst_const: got %b required 0001111", {axi.AWPROT, axi.WSTRB}); end
    rst = 1;
    @(posedge clk); #1;
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL rst_release_ready: got %b required 1", req_ready); end
  endtask

  task automatic test_data_write();
    bit ok;
    logic [2:0] r;
    aw_dly = 0; w_dly = 0; b_dly = 0; b_early = 0; b_resp = 2'b00;
    model_write(32'h1234_5678, 1'b0, 2'b00, 1'b0);
    issue_req(32'h1234_5678, 1'b0, ok);
    if (!ok) return;
    // Now just past edge N.
    tests++; if ({axi.AWVALID, axi.WVALID, req_ready} !== 3'b110) begin fails++; $display("FAIL dw_n_valids: got %b required 110", {axi.AWVALID, axi.WVALID, req_ready}); end
    tests++; if (axi.AWADDR !== 32'h0 || axi.WDATA !== 32'h1234_5678) begin fails++; $display("FAIL dw_n_payload: got %h/%h required 0/12345678", axi.AWADDR, axi.WDATA); end
    @(posedge clk); #1;
    tests++; if ({axi.AWVALID, axi.WVALID, axi.BREADY} !== 3'b001) begin fails++; $display("FAIL dw_n1: got %b required 001", {axi.AWVALID, axi.WVALID, axi.BREADY}); end
    @(posedge clk); #1;
    tests++; if ({resp_valid, resp_code, axi.BREADY} !== 4'b1000) begin fails++; $display("FAIL dw_n2_resp: got %b required 1000", {resp_valid, resp_code, axi.BREADY}); end
    @(posedge clk); #1;
    tests++; if ({resp_valid, req_ready} !== 2'b01) begin fails++; $display("FAIL dw_n3_ready: got %b required 01", {resp_valid, req_ready}); end
    tests++; if ({valid_cnt, invalid_cnt, err_cnt} !== 24'd0) begin fails++; $display("FAIL dw_counters: got %h required 0", {valid_cnt, invalid_cnt, err_cnt}); end
    r = (got_resp_q.size() > 0) ? got_resp_q.pop_front() : 3'bxxx;
    tests++; if (r !== exp_q.pop_front()) begin fails++; $display("FAIL dw_scoreboard: got %b", r); end
    void'(exp_addr_q.pop_front()); void'(exp_data_q.pop_front());
    if (got_aw_q.size() > 0) void'(got_aw_q.pop_front());
    if (got_w_q.size() > 0) void'(got_w_q.pop_front());
  endtask

  task automatic test_commit_writes();
    logic [2:0] r; logic [AW-1:0] a; logic [DW-1:0] d;
    logic [DW-1:0] words [2] = '{32'hA500_0000, 32'h3C00_0000};
    logic [1:0]    codes [2] = '{2'b00, 2'b01};
    for (int i = 0; i < 2; i++) begin
      b_resp = codes[i];
      model_write(words[i], 1'b1, codes[i], 1'b0);
      do_write(words[i], 1'b1, r, a, d);
      tests++; if (a !== exp_addr_q.pop_front()) begin fails++; $display("FAIL commit_addr[%0d]: got %h required 4", i, a); end
      tests++; if (d !== exp_data_q.pop_front()) begin fails++; $display("FAIL commit_data[%0d]: got %h required %h", i, d, words[i]); end
      tests++; if (r !== exp_q.pop_front()) begin fails++; $display("FAIL commit_resp[%0d]: got %b required %b", i, r, {1'b0, codes[i]}); end
      tests++; if ({valid_cnt, invalid_cnt, err_cnt} !== {8'(ev), 8'(ei), 8'(ee)}) begin fails++; $display("FAIL commit_cnt[%0d]: got %0d/%0d/%0d required %0d/%0d/%0d", i, valid_cnt, invalid_cnt, err_cnt, ev, ei, ee); end
    end
  endtask

  task automatic test_aw_delay();
    logic [2:0] r; logic [AW-1:0] a; logic [DW-1:0] d;
    int aw0, w0, p0;
    aw_dly = 3; w_dly = 0; b_dly = 0; b_early = 0; b_resp = 2'b00;
    aw0 = aw_hi_total; w0 = w_hi_total; p0 = proto_err;
    model_write(32'h0BAD_F00D, 1'b0, 2'b00, 1'b0);
    do_write(32'h0BAD_F00D, 1'b0, r, a, d);
    tests++; if (aw_hi_total - aw0 != 4) begin fails++; $display("FAIL awdly_aw_cycles: got %0d required 4", aw_hi_total - aw0); end
    tests++; if (w_hi_total - w0 != 1) begin fails++; $display("FAIL awdly_w_cycles: got %0d required 1", w_hi_total - w0); end
    tests++; if (proto_err != p0) begin fails++; $display("FAIL awdly_protocol: got %0d violations required 0", proto_err - p0); end
    tests++; if ({r, a, d} !== {exp_q.pop_front(), exp_addr_q.pop_front(), exp_data_q.pop_front()}) begin fails++; $display("FAIL awdly_txn: got %b %h %h", r, a, d); end
    aw_dly = 0;
  endtask

  task automatic test_random();
    logic [2:0] r; logic [AW-1:0] a; logic [DW-1:0] d;
    logic [DW-1:0] wd; logic c;
    for (int i = 0; i < 40; i++) begin
      aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3);
      b_dly = $urandom_range(0, 3); b_early = 1'($urandom_range(0, 1));
      b_resp = 2'($urandom_range(0, 3)); c = 1'($urandom_range(0, 1)); wd = $urandom;
      model_write(wd, c, b_resp, 1'b0);
      do_write(wd, c, r, a, d);
      tests++; if ({r, a, d} !== {exp_q.pop_front(), exp_addr_q.pop_front(), exp_data_q.pop_front()}) begin fails++; $display("FAIL rand_txn[%0d]: got resp=%b addr=%h data=%h", i, r, a, d); end
    end
    tests++; if ({valid_cnt, invalid_cnt, err_cnt} !== {8'(ev), 8'(ei), 8'(ee)}) begin fails++; $display("FAIL rand_cnt: got %0d/%0d/%0d required %0d/%0d/%0d", valid_cnt, invalid_cnt, err_cnt, ev, ei, ee); end
    tests++; if (proto_err != 0) begin fails++; $display("FAIL rand_protocol: got %0d violations required 0", proto_err); end
    aw_dly = 0; w_dly = 0; b_dly = 0; b_early = 0;
  endtask

  task automatic test_saturate();
    logic [2:0] r; logic [AW-1:0] a; logic [DW-1:0] d;
    logic [DW-1:0] wd;
    int bad;
    bad = 0; b_resp = 2'b10;
    for (int i = 0; i < 260; i++) begin
      wd = $urandom;
      model_write(wd, 1'b1, 2'b10, 1'b0);
      do_write(wd, 1'b1, r, a, d);
      if ({r, a, d} !== {exp_q.pop_front(), exp_addr_q.pop_front(), exp_data_q.pop_front()}) bad++;
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL sat_txns: got %0d bad transactions required 0", bad); end
    tests++; if (err_cnt !== 8'(ee)) begin fails++; $display("FAIL sat_err_cnt: got %h required %h", err_cnt, 8'(ee)); end
    tests++; if (err_cnt !== 8'hFF) begin fails++; $display("FAIL sat_err_full: got %h required ff", err_cnt); end
    b_resp = 2'b00;
  endtask

  task automatic test_reset_mid();
    bit ok, seen_rv;
    logic [2:0] r; logic [AW-1:0] a; logic [DW-1:0] d;
    b_dly = 100000; b_resp = 2'b00;
    issue_req(32'h5555_AAAA, 1'b1, ok);
    if (!ok) return;
    for (int i = 0; i < 50 && !axi.BREADY; i++) @(negedge clk);
    tests++; if (axi.BREADY !== 1'b1) begin fails++; $display("FAIL rmid_reach_resp: BREADY=%b required 1", axi.BREADY); end
    @(posedge clk); #2;
    rst = 0;
    #1;
    tests++; if ({axi.BREADY, req_ready, axi.AWVALID, axi.WVALID, resp_valid} !== 5'b0) begin fails++; $display("FAIL rmid_outputs: got %b required 00000", {axi.BREADY, req_ready, axi.AWVALID, axi.WVALID, resp_valid}); end
    tests++; if ({axi.AWADDR, axi.WDATA, valid_cnt, invalid_cnt, err_cnt} !== 88'd0) begin fails++; $display("FAIL rmid_regs: got %h required 0", {axi.AWADDR, axi.WDATA, valid_cnt, invalid_cnt, err_cnt}); end
    ev = 0; ei = 0; ee = 0;
    a = (got_aw_q.size() > 0) ? got_aw_q.pop_front() : 'x;
    d = (got_w_q.size() > 0) ? got_w_q.pop_front() : 'x;
    tests++; if ({a, d} !== {32'h4, 32'h5555_AAAA}) begin fails++; $display("FAIL rmid_abandoned_txn: got %h/%h required 4/5555aaaa", a, d); end
    repeat (3) @(negedge clk);
    b_dly = 0;
    rst = 1;
    @(posedge clk); #1;
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL rmid_ready_after: got %b required 1", req_ready); end
    seen_rv = 0;
    repeat (10) begin @(negedge clk); if (resp_valid) seen_rv = 1; end
    tests++; if (seen_rv || got_resp_q.size() != 0) begin fails++; $display("FAIL rmid_no_resp: got resp_valid=%b queued=%0d required none", seen_rv, got_resp_q.size()); end
    model_write(32'h0000_0001, 1'b1, 2'b00, 1'b0);
    do_write(32'h0000_0001, 1'b1, r, a, d);
    tests++; if ({r, a, d} !== {exp_q.pop_front(), exp_addr_q.pop_front(), exp_data_q.pop_front()}) begin fails++; $display("FAIL rmid_fresh_txn: got %b %h %h", r, a, d); end
    tests++; if ({valid_cnt, invalid_cnt, err_cnt} !== {8'(ev), 8'(ei), 8'(ee)}) begin fails++; $display("FAIL rmid_cnt: got %0d/%0d/%0d required %0d/%0d/%0d", valid_cnt, invalid_cnt, err_cnt, ev, ei, ee); end
  endtask

`ifdef AXIL_WR_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    int br;
    logic [2:0] r;
    b_dly = 100000; b_early = 0;
    model_write(32'hDEAD_0001, 1'b1, 2'b00, 1'b1);
    issue_req(32'hDEAD_0001, 1'b1, ok);
    if (!ok) return;
    br = 0;
    for (int i = 0; i < 100 && !resp_valid; i++) begin @(negedge clk); if (axi.BREADY) br++; end
    tests++; if (br != TO_CYC) begin fails++; $display("FAIL to_bready_cycles: got %0d required %0d", br, TO_CYC); end
    tests++; if ({resp_valid, resp_timeout, resp_code} !== 4'b1110) begin fails++; $display("FAIL to_resp: got %b required 1110", {resp_valid, resp_timeout, resp_code}); end
    @(negedge clk);
    r = (got_resp_q.size() > 0) ? got_resp_q.pop_front() : 3'bxxx;
    tests++; if (r !== exp_q.pop_front()) begin fails++; $display("FAIL to_scoreboard: got %b required 110", r); end
    tests++; if (err_cnt !== 8'(ee)) begin fails++; $display("FAIL to_err_cnt: got %0d required %0d", err_cnt, ee); end
    void'(exp_addr_q.pop_front()); void'(exp_data_q.pop_front());
    if (got_aw_q.size() > 0) void'(got_aw_q.pop_front());
    if (got_w_q.size() > 0) void'(got_w_q.pop_front());
    b_dly = 0;
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_data_write();
    test_commit_writes();
    test_aw_delay();
    test_random();
    test_saturate();
    test_reset_mid();
`ifdef AXIL_WR_TIMEOUT_EN
    test_timeout();
`endif
    repeat (5) @(negedge clk);
    tests++; if (got_resp_q.size() != 0) begin fails++; $display("FAIL final_stray_resp: got %0d queued responses required 0", got_resp_q.size()); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
